// File: rtl/dec_tx_pkg.sv
// rtl/dec_tx_pkg.sv - shared state encoding and decimal constants for dec_tx_formatter
// WAIT_S exists only when DEC_TX_SEPARATOR_EN is defined.
package dec_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HUND,
    TENS,
    WAIT_H,
    WAIT_T,
    WAIT_U
`ifdef DEC_TX_SEPARATOR_EN
    , WAIT_S
`endif
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] DEC_HUNDRED = 8'd100;
  localparam logic [7:0] DEC_TEN     = 8'd10;

endpackage

// File: rtl/dec_tx_formatter_byte_fifo.sv
// rtl/dec_tx_formatter_byte_fifo.sv - synchronous byte FIFO, head byte visible on dout while not empty
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dec_tx_formatter.sv
// rtl/dec_tx_formatter.sv - buffers bytes and sends each as three ASCII decimal digits to the UART tx
// Optional trailing separator character per byte when DEC_TX_SEPARATOR_EN is defined.
module dec_tx_formatter
  import dec_tx_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SEP_CHAR   = 8'h20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          tx_start,
  output logic [7:0]                    tx_char,
  input  logic                          tx_done,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  state_t     state;
  logic [7:0] work;
  logic [3:0] h;
  logic [3:0] t;
  logic [3:0] u;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       done_ok;

  assign pop     = (state == LOAD);
  assign busy    = !fifo_empty || (state != IDLE);
  // A tx_done coinciding with our own tx_start belongs to an earlier character.
  assign done_ok = tx_done && !tx_start;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifndef DEC_TX_SEPARATOR_EN
  logic [7:0] unused_sep;
  assign unused_sep = SEP_CHAR;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      work     <= '0;
      h        <= '0;
      t        <= '0;
      u        <= '0;
      tx_char  <= '0;
      tx_start <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      overflow <= in_valid && fifo_full && !pop;
      case (state)
        IDLE: if (!fifo_empty) state <= LOAD;
        LOAD: begin
          work  <= fifo_dout;
          h     <= '0;
          t     <= '0;
          state <= HUND;
        end
        HUND: begin
          if (work >= DEC_HUNDRED) begin
            work <= work - DEC_HUNDRED;
            h    <= h + 4'd1;
          end else begin
            state <= TENS;
          end
        end
        TENS: begin
          if (work >= DEC_TEN) begin
            work <= work - DEC_TEN;
            t    <= t + 4'd1;
          end else begin
            u        <= work[3:0];
            tx_char  <= ASCII_ZERO + {4'h0, h};
            tx_start <= 1'b1;
            state    <= WAIT_H;
          end
        end
        WAIT_H: if (done_ok) begin
          tx_char  <= ASCII_ZERO + {4'h0, t};
          tx_start <= 1'b1;
          state    <= WAIT_T;
        end
        WAIT_T: if (done_ok) begin
          tx_char  <= ASCII_ZERO + {4'h0, u};
          tx_start <= 1'b1;
          state    <= WAIT_U;
        end
`ifdef DEC_TX_SEPARATOR_EN
        WAIT_U: if (done_ok) begin
          tx_char  <= SEP_CHAR;
          tx_start <= 1'b1;
          state    <= WAIT_S;
        end
        WAIT_S: if (done_ok) state <= IDLE;
`else
        WAIT_U: if (done_ok) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_tx_formatter.sv
// tb/tb_dec_tx_formatter.sv - directed self-checking bench for dec_tx_formatter
// Expects a trailing 8'h20 per byte when DEC_TX_SEPARATOR_EN is defined.
module tb_dec_tx_formatter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       tx_start;
  logic [7:0] tx_char;
  logic       tx_done = 1'b0;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  dec_tx_formatter #(.FIFO_DEPTH(4), .SEP_CHAR(8'h20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .tx_start   (tx_start),
    .tx_char    (tx_char),
    .tx_done    (tx_done),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_start(output int cnt);
    cnt = 0;
    while (!tx_start && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    if (!tx_start) chk("tx_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    chk("start_one_cycle", tx_start, 1'b0);
    @(negedge clk);
    pulse_done();
  endtask

  task automatic get_char(input logic [7:0] exp);
    int n;
    wait_start(n);
    chk("tx_char", tx_char, exp);
    ack();
  endtask

  task automatic get_byte(input logic [7:0] v);
    get_char(8'h30 + v / 100);
    get_char(8'h30 + (v / 10) % 10);
    get_char(8'h30 + v % 10);
`ifdef DEC_TX_SEPARATOR_EN
    get_char(8'h20);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ovf;
    int starts;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_char", tx_char, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 65 -> "065", first tx_start in cycle 11
    push(8'h41);
    wait_start(n);
    chk("lat_65", 1 + n, 11);
    get_char(8'h30);
    get_char(8'h36);
    wait_start(n);
    chk("char_5", tx_char, 8'h35);
`ifdef DEC_TX_SEPARATOR_EN
    ack();
    wait_start(n);
    chk("sep_char", tx_char, 8'h20);
`endif
    chk("busy_before_last", busy, 1'b1);
    ack();
    chk("busy_after_last", busy, 1'b0);

    // digit boundaries and latency extremes
    push(8'd0);
    wait_start(n);
    chk("lat_0", 1 + n, 5);
    get_byte(8'd0);
    push(8'd9);
    get_byte(8'd9);
    push(8'd100);
    get_byte(8'd100);
    push(8'd255);
    wait_start(n);
    chk("lat_255", 1 + n, 12);
    get_byte(8'd255);

    // six back-to-back bytes with transmitter stalled: one dropped
    ovf = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd250 + 8'(i);
      @(negedge clk);
      ovf += int'(overflow);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ovf += int'(overflow);
    end
    chk("overflow_pulses", ovf, 1);
    chk("count_full", fifo_count, 3'd4);
    chk("busy_full", busy, 1'b1);
    get_byte(8'd250);

    // push into full FIFO in the LOAD pop cycle
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd7;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pop_push_no_ovf", overflow, 1'b0);
    chk("pop_push_count", fifo_count, 3'd4);
    @(negedge clk);
    chk("pop_push_no_ovf2", overflow, 1'b0);
    get_byte(8'd251);
    get_byte(8'd252);
    get_byte(8'd253);
    get_byte(8'd254);
    get_byte(8'd7);
    chk("drained_count", fifo_count, 3'd0);
    chk("drained_busy", busy, 1'b0);

    // spurious tx_done in IDLE and alongside tx_start
    pulse_done();
    @(negedge clk);
    chk("idle_done_start", tx_start, 1'b0);
    chk("idle_done_busy", busy, 1'b0);
    push(8'd123);
    wait_start(n);
    chk("lat_123", 1 + n, 8);
    chk("char_1", tx_char, 8'h31);
    pulse_done();
    chk("same_cycle_start", tx_start, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("same_cycle_no_skip", tx_start, 1'b0);
    chk("same_cycle_char", tx_char, 8'h31);
    pulse_done();
    get_char(8'h32);
    get_char(8'h33);
`ifdef DEC_TX_SEPARATOR_EN
    get_char(8'h20);
`endif

    // reset during WAIT_T
    push(8'd42);
    push(8'd99);
    get_char(8'h30);
    wait_start(n);
    chk("wait_t_char", tx_char, 8'h34);
    rst_n = 1'b0;
    #1;
    chk("async_rst_start", tx_start, 1'b0);
    chk("async_rst_count", fifo_count, 3'd0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_char", tx_char, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 5) tx_done = 1'b1;
      if (i == 6) tx_done = 1'b0;
      starts += int'(tx_start);
    end
    chk("post_rst_silent", starts, 0);

    // recovery; with separator enabled this gives "042" then 8'h20
    push(8'd42);
    get_byte(8'd42);
    chk("final_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_tx_formatter.md
Name: dec_tx_formatter

Overview:
- Sits between the UART receiver and the UART transmitter.
- Buffers received bytes in a small FIFO and converts each byte sequentially into three ASCII decimal digits, hundreds first.
- Drives the transmitter's start/done handshake one character at a time.
- Decouples back-to-back received bytes from the slower transmit path, so no byte is lost while a previous byte is still being sent.

Parameters:
- FIFO_DEPTH, 4: byte FIFO entries; power of two, minimum 2.
- SEP_CHAR, 8'h20: separator character, used only when SEPARATOR_EN is defined.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- in_valid  input  1  one-cycle strobe; in_data is valid while it is high.
- in_data  input  8  received byte.
- tx_start  output  1  one-cycle pulse to the transmitter to start sending tx_char.
- tx_char  output  8  character to transmit; held stable from tx_start until tx_done.
- tx_done  input  1  one-cycle pulse from the transmitter when a character has completed.
- busy  output  1  high while the FIFO is non-empty or the FSM is not in IDLE.
- overflow  output  1  one-cycle pulse when an input byte is dropped.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - On reset: tx_start=0, tx_char=8'h00, overflow=0, busy=0, fifo_count=0, FSM in IDLE, pointers and digit registers cleared.
  - Reset asserted mid-character: tx_start drops immediately and the in-flight byte is discarded.
- FIFO write:
  - Occurs on in_valid when count<FIFO_DEPTH, or when the FIFO is full and a pop happens in the same cycle (count unchanged).
  - Otherwise the byte is dropped and overflow pulses for one cycle.
- FIFO pop: happens only in LOAD.
- FSM states:
  - IDLE: go to LOAD when count!=0.
  - LOAD: work<=head byte, h<=0, t<=0, pop; go to HUND.
  - HUND: if work>=100 then work-=100, h++, stay; else go to TENS. h is at most 2.
  - TENS: if work>=10 then work-=10, t++, stay; else u<=work, tx_char<=8'h30+h, tx_start<=1, go to WAIT_H. t is at most 9.
  - WAIT_H: on tx_done, tx_char<=8'h30+t, tx_start<=1, go to WAIT_T.
  - WAIT_T: on tx_done, tx_char<=8'h30+u, tx_start<=1, go to WAIT_U.
  - WAIT_U: on tx_done, go to IDLE; with SEPARATOR_EN, go to WAIT_S instead (see Optional Feature).
- Timing:
  - Digits are always three characters, leading zeros included ("007").
  - tx_start is registered and high for exactly one cycle per character.
  - Latency: with an empty FIFO and the FSM in IDLE, in_valid in cycle 0 gives the first tx_start in cycle 5+h+t. Byte 0 gives cycle 5; byte 255 gives cycle 12.
  - From IDLE with count!=0, the next byte's tx_start follows 4+h+t cycles later.
- Boundary conditions:
  - tx_done outside the WAIT_* states is ignored.
  - tx_done arriving in the same cycle as tx_start is ignored.
  - in_valid is accepted in every FSM state; the FIFO is independent of the FSM.
- Arithmetic: work register is 8 bits unsigned; digit registers are 4 bits; ASCII = 8'h30 + digit, zero-extended.

Optional Feature:
- Macro: DEC_TX_SEPARATOR_EN.
- Defined:
  - In WAIT_U, on tx_done, set tx_char<=SEP_CHAR, pulse tx_start, go to WAIT_S.
  - In WAIT_S, on tx_done, go to IDLE.
  - Four characters per byte.
- Undefined: WAIT_S does not exist; exactly three characters per byte.

Decomposition:
- Package dec_tx_pkg holds:
  - FSM state encoding (IDLE, LOAD, HUND, TENS, WAIT_H, WAIT_T, WAIT_U, WAIT_S).
  - Constants ASCII_ZERO=8'h30, DEC_HUNDRED=8'd100, DEC_TEN=8'd10.
- Sub-module byte_fifo: synchronous FIFO parameterised by depth; ports push, pop, din, dout, count, full, empty. Head data (dout) is valid while not empty.

Test Plan:
- Reset, then in_valid with 8'h41 (65) -> tx_start at cycle 11; chars 8'h30, 8'h36, 8'h35 each after tx_done; busy falls after the third tx_done.
- Bytes 0, 9, 100, 255 sequentially -> "000", "009", "100", "255"; byte 255 first tx_start in cycle 12 relative to in_valid.
- FIFO_DEPTH=4, 6 back-to-back in_valid while the transmitter is stalled -> FSM holds 1 byte and FIFO holds 4; byte 6 is dropped with overflow pulsing once; fifo_count=4; 5 triplets are eventually sent in order.
- FIFO full and a push in the same cycle as the LOAD pop -> byte accepted, no overflow, fifo_count stays 4.
- Spurious tx_done in IDLE and in the same cycle as tx_start -> ignored; no skipped digit.
- rst_n low during WAIT_T -> tx_start=0 and count=0 immediately; no further characters; with DEC_TX_SEPARATOR_EN, byte 42 -> "042" followed by 8'h20.
